// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared constants and types for the ghost behaviour logic:
//   - mode encodings driven on the scheduler's mode output
//   - ghost scheduler FSM state enum
//   - scatter/chase phase duration table and reload helper
//   - frightened-period timing constants
// ---------------------------------------------------------------------------
package game_pkg;

    localparam logic [1:0] MODE_SCATTER = 2'b00;
    localparam logic [1:0] MODE_CHASE   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCATTER,
        ST_CHASE,
        ST_FRIGHT
    } ghost_state_t;

    localparam int unsigned PHASE_W  = 11;
    localparam int unsigned FRIGHT_W = 9;
    localparam int unsigned FLASH_W  = 4;

    localparam int unsigned FRIGHT_TICKS = 360;
    localparam int unsigned FLASH_TICKS  = 120;
    localparam int unsigned FLASH_HALF   = 15;

    localparam logic [2:0] LAST_PHASE = 3'd7;

    // Duration of each schedule phase in unpaused cycles; the last phase
    // never expires and is encoded as 0.
    function automatic logic [PHASE_W-1:0] phase_ticks(input logic [2:0] ph);
        logic [PHASE_W-1:0] t;
        case (ph)
            3'd0:    t = 11'd420;
            3'd1:    t = 11'd1200;
            3'd2:    t = 11'd420;
            3'd3:    t = 11'd1200;
            3'd4:    t = 11'd300;
            3'd5:    t = 11'd1200;
            3'd6:    t = 11'd300;
            default: t = '0;
        endcase
        return t;
    endfunction

    // Down-counter reload value: duration-1 so the phase lasts exactly
    // its duration including the advancing cycle.
    function automatic logic [PHASE_W-1:0] phase_reload(input logic [2:0] ph);
        logic [PHASE_W-1:0] t;
        t = phase_ticks(ph);
        return (t == '0) ? '0 : t - PHASE_W'(1);
    endfunction

    // Even phases scatter, odd phases chase.
    function automatic ghost_state_t phase_state(input logic [2:0] ph);
        return ph[0] ? ST_CHASE : ST_SCATTER;
    endfunction

endpackage

// File: rtl/ghost_mode_scheduler_tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer
// Loadable down-counter with enable and zero flag. The count saturates at
// zero; the owner reloads it when it acts on expiry.
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset (count -> 0)
//   i_clr       synchronous clear, highest priority
//   i_load      load i_load_val
//   i_load_val  value loaded
//   i_en        decrement by one
//   o_count     current count
//   o_zero      count == 0
// ---------------------------------------------------------------------------
module tick_timer #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/ghost_mode_scheduler.sv
// ---------------------------------------------------------------------------
// ghost_mode_scheduler
// Global ghost mode schedule: walks the scatter/chase phase table, handles
// frightened periods triggered by power pellets, and produces the ghost
// reverse command and end-of-fright flash.
// Ports:
//   clk           60 Hz game tick
//   rst           asynchronous active-low reset
//   level_rst     synchronous clear, active-high
//   start         begin scheduling (only honoured in IDLE)
//   pause         global freeze of all timers, FSM and outputs
//   power_pellet  one-cycle pellet-eaten pulse
//   mode          MODE_SCATTER / MODE_CHASE (saved mode while frightened)
//   fright        frightened period active
//   fright_flash  end-of-fright blink
//   reverse       one-cycle ghost reverse command
//   phase         schedule index 0..7
// All outputs are registered.
// ---------------------------------------------------------------------------
module ghost_mode_scheduler
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       level_rst,
    input  logic       start,
    input  logic       pause,
    input  logic       power_pellet,
    output logic [1:0] mode,
    output logic       fright,
    output logic       fright_flash,
    output logic       reverse,
    output logic [2:0] phase
);

    localparam logic [FRIGHT_W-1:0] FRIGHT_RELOAD = FRIGHT_W'(FRIGHT_TICKS - 1);
    // Count value that becomes FLASH_TICKS-1 after the next decrement.
    localparam logic [FRIGHT_W-1:0] FLASH_EDGE    = FRIGHT_W'(FLASH_TICKS);
    localparam logic [FLASH_W-1:0]  FLASH_LAST    = FLASH_W'(FLASH_HALF - 1);

    ghost_state_t r_state, w_state_nxt;
    ghost_state_t r_saved, w_saved_nxt;
    logic [2:0]   r_phase, w_phase_nxt, w_phase_inc;

    logic               w_ph_load, w_ph_en, w_ph_zero;
    logic [PHASE_W-1:0] w_ph_load_val, w_ph_count;
    logic               w_unused_ph_count;

    logic                w_fr_load, w_fr_en, w_fr_zero;
    logic [FRIGHT_W-1:0] w_fr_count;

    logic               w_rev_nxt;
    logic [1:0]         r_mode, w_mode_nxt;
    logic               r_fright, w_fright_nxt;
    logic               r_flash, w_flash_nxt;
    logic               r_reverse;
    logic               r_window, w_window_nxt;
    logic [FLASH_W-1:0] r_flash_sub, w_flash_sub_nxt;
    logic               r_flash_bit, w_flash_bit_nxt;

    assign w_phase_inc = r_phase + 3'd1;

    // Phase expiry is observed only through the zero flag.
    assign w_unused_ph_count = ^w_ph_count;

    tick_timer #(.W(PHASE_W)) u_phase_timer (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_clr      (level_rst),
        .i_load     (w_ph_load),
        .i_load_val (w_ph_load_val),
        .i_en       (w_ph_en),
        .o_count    (w_ph_count),
        .o_zero     (w_ph_zero)
    );

    tick_timer #(.W(FRIGHT_W)) u_fright_timer (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_clr      (level_rst),
        .i_load     (w_fr_load),
        .i_load_val (FRIGHT_RELOAD),
        .i_en       (w_fr_en),
        .o_count    (w_fr_count),
        .o_zero     (w_fr_zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_saved <= ST_SCATTER;
            r_phase <= '0;
        end else if (level_rst) begin
            r_state <= ST_IDLE;
            r_saved <= ST_SCATTER;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_saved <= w_saved_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Next-state logic. Nothing advances while paused; a pellet outranks a
    // simultaneous phase expiry, leaving the phase counter untouched.
    always_comb begin
        w_state_nxt   = r_state;
        w_saved_nxt   = r_saved;
        w_phase_nxt   = r_phase;
        w_ph_load     = 1'b0;
        w_ph_load_val = '0;
        w_ph_en       = 1'b0;
        w_fr_load     = 1'b0;
        w_fr_en       = 1'b0;
        w_rev_nxt     = 1'b0;
        if (!pause) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt   = ST_SCATTER;
                        w_phase_nxt   = '0;
                        w_ph_load     = 1'b1;
                        w_ph_load_val = phase_reload(3'd0);
                    end
                end
                ST_SCATTER, ST_CHASE: begin
                    if (power_pellet) begin
                        w_state_nxt = ST_FRIGHT;
                        w_saved_nxt = r_state;
                        w_fr_load   = 1'b1;
                        w_rev_nxt   = 1'b1;
                    end else if (r_phase != LAST_PHASE) begin
                        if (w_ph_zero) begin
                            w_phase_nxt   = w_phase_inc;
                            w_state_nxt   = phase_state(w_phase_inc);
                            w_ph_load     = 1'b1;
                            w_ph_load_val = phase_reload(w_phase_inc);
                            w_rev_nxt     = 1'b1;
                        end else begin
                            w_ph_en = 1'b1;
                        end
                    end
                end
                ST_FRIGHT: begin
                    if (power_pellet) begin
                        w_fr_load = 1'b1;
                        w_rev_nxt = 1'b1;
                    end else if (w_fr_zero) begin
                        w_state_nxt = r_saved;
                    end else begin
                        w_fr_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: next values of the registered outputs. The flash window
    // is derived from the count after this cycle's decrement so that the
    // registered flag lines up with the registered fright output.
    always_comb begin
        w_mode_nxt = MODE_SCATTER;
        if ((w_state_nxt == ST_CHASE) ||
            ((w_state_nxt == ST_FRIGHT) && (w_saved_nxt == ST_CHASE))) begin
            w_mode_nxt = MODE_CHASE;
        end
        w_fright_nxt = (w_state_nxt == ST_FRIGHT);

        w_window_nxt    = r_window;
        w_flash_sub_nxt = r_flash_sub;
        w_flash_bit_nxt = r_flash_bit;
        if (!pause) begin
            w_window_nxt = w_fright_nxt && !w_fr_load && (w_fr_count <= FLASH_EDGE);
            if (!w_window_nxt) begin
                w_flash_sub_nxt = '0;
                w_flash_bit_nxt = 1'b0;
            end else if (!r_window) begin
                w_flash_sub_nxt = '0;
                w_flash_bit_nxt = 1'b1;
            end else if (r_flash_sub == FLASH_LAST) begin
                w_flash_sub_nxt = '0;
                w_flash_bit_nxt = ~r_flash_bit;
            end else begin
                w_flash_sub_nxt = r_flash_sub + FLASH_W'(1);
            end
        end
        w_flash_nxt = w_window_nxt && w_flash_bit_nxt;
    end

    // Output registers. Reverse is recomputed every cycle, so it drops
    // during pause instead of repeating the command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode      <= MODE_SCATTER;
            r_fright    <= 1'b0;
            r_flash     <= 1'b0;
            r_reverse   <= 1'b0;
            r_window    <= 1'b0;
            r_flash_sub <= '0;
            r_flash_bit <= 1'b0;
        end else if (level_rst) begin
            r_mode      <= MODE_SCATTER;
            r_fright    <= 1'b0;
            r_flash     <= 1'b0;
            r_reverse   <= 1'b0;
            r_window    <= 1'b0;
            r_flash_sub <= '0;
            r_flash_bit <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_fright    <= w_fright_nxt;
            r_flash     <= w_flash_nxt;
            r_reverse   <= w_rev_nxt;
            r_window    <= w_window_nxt;
            r_flash_sub <= w_flash_sub_nxt;
            r_flash_bit <= w_flash_bit_nxt;
        end
    end

    assign mode         = r_mode;
    assign fright       = r_fright;
    assign fright_flash = r_flash;
    assign reverse      = r_reverse;
    assign phase        = r_phase;

endmodule
